cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits directly downstream of the pipelined CPU's split instruction and data caches.
- Multiplexes their line-sized miss/writeback traffic onto the single physical memory port.
- Owns grant selection, request latching, response steering and a one-cycle release gap between transactions.
- The CPU-side caches see independent pmem-style ports; physical memory sees one requester.

Parameters:
ADDR_WIDTH, 16, byte address width of all ports
LINE_WIDTH, 128, cache line width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  I-cache line fill request
i_pmem_address  in  ADDR_WIDTH  I-cache line address
i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache
i_pmem_resp  out  1  I-cache transaction complete
d_pmem_read  in  1  D-cache line fill request
d_pmem_write  in  1  D-cache writeback request
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache
d_pmem_resp  out  1  D-cache transaction complete
pmem_read  out  1  physical memory read
pmem_write  out  1  physical memory write
pmem_address  out  ADDR_WIDTH  physical address, low log2(LINE_WIDTH/8) bits forced 0
pmem_wdata  out  LINE_WIDTH  physical write data
pmem_rdata  in  LINE_WIDTH  physical read data
pmem_resp  in  1  physical transaction complete
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=I.
  - Latched address/wdata/op cleared to 0.
  - pmem_read, pmem_write, i_pmem_resp, d_pmem_resp and busy all 0 immediately.
  - rdata outputs 0.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE transitions:
  - Only I requests: latch i_pmem_address, op=read, go to SERVE_I.
  - Only D requests: latch d_pmem_address, d_pmem_wdata and op, go to SERVE_D.
  - Both request in the same cycle: grant the side not equal to last_grant. Since reset sets last_grant=I, the first conflict goes to D. This gives round-robin on conflict and no starvation.
  - last_grant updates on every grant.
- D op encoding: d_pmem_write=1 gives a write, even if d_pmem_read=1 (write wins). Otherwise a read.
- SERVE_x:
  - pmem_read/pmem_write are driven from the latched op, registered, and asserted from the first SERVE cycle.
  - pmem_address and pmem_wdata come from the latches, stable for the whole transaction.
  - Requester input changes during SERVE are ignored.
- Response:
  - On the SERVE_x cycle where pmem_resp=1, assert x_pmem_resp=1 combinationally that same cycle.
  - x_pmem_rdata=pmem_rdata, combinational pass-through, valid only while x_pmem_resp=1.
  - The non-granted side's resp is held 0 and its rdata 0.
  - Next state is RELEASE. pmem_read/pmem_write deassert at that edge.
- RELEASE:
  - Lasts exactly 1 cycle. No pmem command, no resp.
  - Requests are ignored, so a requester still holding its request from the resp cycle is not re-served.
  - Then go to IDLE; arbitration resumes the following cycle.
- Latency:
  - Request seen in IDLE at cycle N → pmem command asserted at cycle N+1.
  - Resp at cycle N+k → requester resp at N+k.
  - Earliest next grant decision at N+k+2.
- pmem_resp outside SERVE states is ignored.
- A request arriving at a non-granted side during SERVE waits; it is arbitrated in the first IDLE cycle.
- Reset mid-transaction: abandon immediately, with no resp to either side. Memory-side consequences are the memory model's concern.
- No combinational path from requester inputs to pmem outputs; pmem_* are registered or latched.

Test Plan:
- Single I read: i_pmem_read=1, addr 0x1230, memory resp after 5 cycles with data 0xA5..A5 → pmem_read high from cycle 1 at addr 0x1230; i_pmem_resp high for 1 cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0; busy low 2 cycles after resp.
- D writeback: d_pmem_write=1, addr 0x8010, wdata 0xDEADBEEF repeated → pmem_write=1, pmem_address=0x8010, pmem_wdata matches; d_pmem_resp pulses once; pmem_read never asserted.
- Simultaneous requests after reset: I addr 0x0040, D read addr 0x2000, both held → D served first, then RELEASE, then I served; a second simultaneous pair is served I first.
- Held request through RELEASE: I holds i_pmem_read one cycle past i_pmem_resp → no second pmem_read for I; next transaction starts only on a fresh request in IDLE.
- D read+write both high at addr 0x3000 → treated as write: pmem_write=1, pmem_read=0.
- rst_n asserted mid-SERVE_D with pmem_resp not yet returned → pmem_write/pmem_read drop to 0 in the same cycle; no d_pmem_resp; after release an I request at 0x0100 is granted normally; first later conflict goes to D.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates the split I/D cache pmem ports onto one physical memory port.
// Round-robin on conflict, latched request, one idle RELEASE cycle per transaction.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // I-cache side
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // D-cache side
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  busy
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_I,
    ST_SERVE_D,
    ST_RELEASE
  } state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  state_t                r_state;
  grant_t                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_pmem_read;
  logic                  r_pmem_write;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;
  logic w_i_resp;
  logic w_d_resp;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;
  // On a conflict the side that did not win last time takes the grant.
  assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == GRANT_I));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_I;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state      <= ST_SERVE_D;
            r_last_grant <= GRANT_D;
            r_addr       <= d_pmem_address & ADDR_MASK;
            r_wdata      <= d_pmem_wdata;
            r_pmem_write <= d_pmem_write;
            r_pmem_read  <= ~d_pmem_write;
          end else if (w_i_req) begin
            r_state      <= ST_SERVE_I;
            r_last_grant <= GRANT_I;
            r_addr       <= i_pmem_address & ADDR_MASK;
            r_wdata      <= '0;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (pmem_resp) begin
            r_state      <= ST_RELEASE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Responses pass straight through in the completing cycle, gated to the owner.
  assign w_i_resp = (r_state == ST_SERVE_I) & pmem_resp;
  assign w_d_resp = (r_state == ST_SERVE_D) & pmem_resp;

  assign i_pmem_resp  = w_i_resp;
  assign d_pmem_resp  = w_d_resp;
  assign i_pmem_rdata = w_i_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = w_d_resp ? pmem_rdata : '0;

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: inputs driven and outputs
// sampled around the falling edge, expectations computed by hand.
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    pmem_resp  = 1'b1;
    pmem_rdata = {LW{1'b1}};
    @(negedge clk); #1;
    checks++;
    if ({pmem_read, pmem_write, busy, i_pmem_resp, d_pmem_resp} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {pmem_read, pmem_write, busy, i_pmem_resp, d_pmem_resp});
    end
    checks++;
    if (i_pmem_rdata !== '0 || d_pmem_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got i=%h d=%h exp 0", i_pmem_rdata, d_pmem_rdata);
    end
    checks++;
    if (pmem_address !== '0 || pmem_wdata !== '0) begin
      errors++; $display("FAIL reset_latch got a=%h w=%h exp 0", pmem_address, pmem_wdata);
    end
    // pmem_resp while IDLE must be ignored
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
      errors++; $display("FAIL idle_resp got i=%b d=%b exp 0", i_pmem_resp, d_pmem_resp);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pmem_read !== 1'b0) begin
      errors++; $display("FAIL idle_stay got busy=%b rd=%b exp 0", busy, pmem_read);
    end
    clear_inputs();
  endtask

  task automatic test_single_i_read();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++; $display("FAIL i_comb_path pmem_read got %b exp 0", pmem_read);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230 || i_pmem_resp !== 1'b0) begin
        errors++; $display("FAIL i_wait%0d got rd=%b wr=%b a=%h resp=%b exp 1 0 1230 0", k, pmem_read, pmem_write, pmem_address, i_pmem_resp);
      end
    end
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = {16{8'hA5}};
    #1;
    checks++;
    if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== {16{8'hA5}} || d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin
      errors++; $display("FAIL i_resp got r=%b data=%h d_r=%b d_data=%h exp 1 a5.. 0 0", i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (busy !== 1'b1 || pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
      errors++; $display("FAIL i_release got busy=%b rd=%b resp=%b exp 1 0 0", busy, pmem_read, i_pmem_resp);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL i_idle busy got %b exp 0", busy);
    end
  endtask

  task automatic test_d_writeback();
    int d_pulses = 0;
    int rd_seen  = 0;
    @(negedge clk);
    d_pmem_write = 1'b1; d_pmem_address = 16'h8010; d_pmem_wdata = {4{32'hDEADBEEF}};
    @(negedge clk); #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h8010 || pmem_wdata !== {4{32'hDEADBEEF}}) begin
      errors++; $display("FAIL d_wb_cmd got wr=%b a=%h w=%h exp 1 8010 deadbeef..", pmem_write, pmem_address, pmem_wdata);
    end
    // requester changes during SERVE are ignored
    d_pmem_address = 16'hFFF0; d_pmem_wdata = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      pmem_resp = (k == 2);
      #1;
      if (d_pmem_resp === 1'b1) d_pulses++;
      if (pmem_read !== 1'b0) rd_seen++;
      if (k == 2) begin
        checks++;
        if (pmem_address !== 16'h8010 || pmem_wdata !== {4{32'hDEADBEEF}} || i_pmem_resp !== 1'b0) begin
          errors++; $display("FAIL d_wb_stable got a=%h w=%h i_r=%b exp 8010 deadbeef.. 0", pmem_address, pmem_wdata, i_pmem_resp);
        end
        d_pmem_write = 1'b0;
      end
    end
    checks++;
    if (d_pulses != 1) begin
      errors++; $display("FAIL d_wb_pulses got %0d exp 1", d_pulses);
    end
    checks++;
    if (rd_seen != 0 || pmem_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL d_wb_end got rd_seen=%0d wr=%b busy=%b exp 0 0 0", rd_seen, pmem_write, busy);
    end
    clear_inputs();
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h2000) begin
      errors++; $display("FAIL conf1_d_first got rd=%b a=%h exp 1 2000", pmem_read, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = {4{32'h12345678}};
    #1;
    checks++;
    if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== {4{32'h12345678}} || i_pmem_resp !== 1'b0 || i_pmem_rdata !== '0) begin
      errors++; $display("FAIL conf1_d_resp got d=%b dd=%h i=%b id=%h", d_pmem_resp, d_pmem_rdata, i_pmem_resp, i_pmem_rdata);
    end
    // D issues a fresh request during RELEASE; it meets the held I request in IDLE
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0; d_pmem_address = 16'h2040;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL conf_release got rd=%b busy=%b exp 0 1", pmem_read, busy);
    end
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0040) begin
      errors++; $display("FAIL conf2_i_first got rd=%b a=%h exp 1 0040", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
      errors++; $display("FAIL conf2_i_resp got i=%b d=%b exp 1 0", i_pmem_resp, d_pmem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h2040) begin
      errors++; $display("FAIL conf2_d_next got rd=%b a=%h exp 1 2040", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_held_through_release();
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h0500;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_read !== 1'b1 || i_pmem_resp !== 1'b1) begin
      errors++; $display("FAIL held_resp got rd=%b resp=%b exp 1 1", pmem_read, i_pmem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    i_pmem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL held_no_reserve got rd=%b busy=%b exp 0 0", pmem_read, busy);
    end
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h060F;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++; $display("FAIL held_still_idle rd got %b exp 0", pmem_read);
    end
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0600) begin
      errors++; $display("FAIL held_fresh got rd=%b a=%h exp 1 0600", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h3000;
    d_pmem_wdata = {8{16'hC0DE}};
    @(negedge clk); #1;
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h3000) begin
      errors++; $display("FAIL rw_write_wins got wr=%b rd=%b a=%h exp 1 0 3000", pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_serve();
    @(negedge clk);
    d_pmem_write = 1'b1; d_pmem_address = 16'h4000; d_pmem_wdata = {LW{1'b1}};
    @(negedge clk); #1;
    checks++;
    if (pmem_write !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre wr got %b exp 1", pmem_write);
    end
    rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || busy !== 1'b0 || d_pmem_resp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop got wr=%b rd=%b busy=%b d_r=%b exp 0", pmem_write, pmem_read, busy, d_pmem_resp);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0100 || d_pmem_resp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_i got rd=%b a=%h d_r=%b exp 1 0100 0", pmem_read, pmem_address, d_pmem_resp);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    i_pmem_read = 1'b1; i_pmem_address = 16'h0200;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0300;
    @(negedge clk); #1;
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0300) begin
      errors++; $display("FAIL rst_mid_conf got rd=%b a=%h exp 1 0300", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_conflict();
    test_held_through_release();
    test_read_write_both();
    test_reset_mid_serve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
